traffic_queue_sensor: RTL and testbench
=======================================

TRAFFIC_QUEUE_SENSOR -- requirements
Module: traffic_queue_sensor

Interface
REQ-001 SHALL have parameter QW, default 4: queue counter width; the queue saturates at 2^QW-1.
REQ-002 SHALL have parameter DEPART_CYC, default 2: green cycles per departing vehicle; legal range >=1.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port SA, input, 2: street A light code.
REQ-006 SHALL have port SB, input, 2: street B light code.
REQ-007 SHALL have port arr_a, input, 1: one-cycle vehicle-arrival pulse, street A.
REQ-008 SHALL have port arr_b, input, 1: one-cycle vehicle-arrival pulse, street B.
REQ-009 SHALL have port TA, output, 1: street A traffic present; feeds the controller.
REQ-010 SHALL have port TB, output, 1: street B traffic present; feeds the controller.
REQ-011 SHALL have port qa, output, QW: street A queue count.
REQ-012 SHALL have port qb, output, QW: street B queue count.
REQ-013 SHALL have port drop_a, output, 1: one-cycle pulse, arrival lost to saturation, street A.
REQ-014 SHALL have port drop_b, output, 1: one-cycle pulse, arrival lost to saturation, street B.
REQ-015 SHALL have port viol, output, 1: sticky protocol-violation flag.
REQ-016 SHALL have port viol_code, output, 3: cause of the first violation.

Function
REQ-017 SHALL decode light codes as RED=00, YELLOW=01, GREEN=10; code 11 is illegal.
REQ-018 SHALL drive TA = (qa!=0) and TB = (qb!=0) from registered counts only, with no combinational path from any input.
REQ-019 SHALL hold a per-street departure timer at 0 while the light is not GREEN; while GREEN, the timer counts 0..DEPART_CYC-1 and wraps to 0.
REQ-020 SHALL assert a departure in the cycle the timer equals DEPART_CYC-1 and the queue is nonzero; a YELLOW or RED light never produces a departure.
REQ-021 SHALL update the queue on the next clock edge: arrival only -> +1; departure only -> -1; both -> unchanged; neither -> unchanged.
REQ-022 SHALL hold the queue at 2^QW-1 on an arrival with no departure when saturated, and pulse drop_x high for exactly one cycle.
REQ-023 SHALL keep per-street registers prev_x holding last cycle's light code.
REQ-024 SHALL accept these per-street transitions as legal: hold, GREEN->YELLOW, YELLOW->RED, RED->GREEN; all other transitions are illegal sequences.
REQ-025 SHALL flag a conflict when SA and SB are both non-RED in the same cycle.
REQ-026 SHALL encode viol_code as: 1 illegal code 11 on SA or SB; 2 conflict; 3 illegal sequence on A; 4 illegal sequence on B; priority 1>2>3>4 when events coincide.
REQ-027 SHALL set viol and capture viol_code one cycle after the first violation, then hold both until reset; later violations SHALL NOT change viol_code.
REQ-028 SHALL leave queue and timer behaviour unaffected by violations, treating code 11 as not GREEN.

Reset
REQ-029 SHALL reset to qa=qb=0, TA=TB=0, drop_a=drop_b=0, viol=0, viol_code=0, timers=0, prev_a=prev_b=RED.
REQ-030 SHALL take effect immediately on reset assertion mid-operation, discarding queued vehicles; the first edge after release SHALL evaluate transitions from RED.

Configuration
REQ-031 SHALL, with TRAFFIC_CHECK_EN defined, include the violation checker per REQ-023..REQ-027.
REQ-032 SHALL, with TRAFFIC_CHECK_EN undefined, omit prev_x and the checker logic and tie viol=0, viol_code=0; queue behaviour is unchanged.

Structure
REQ-033 SHALL define in shared package traffic_pkg the light-code constants RED, YELLOW, GREEN, the light-code type, and the viol_code constants.
REQ-034 SHALL implement one street (queue counter, departure timer, drop pulse, sequence check) as sub-module traffic_lane, instantiated twice; conflict detection and viol priority SHALL reside in the top level.

Verification
REQ-035 SHALL cover: SA=RED, three arr_a pulses -> qa=3 and TA=1 one cycle after the first pulse; no departures occur.
REQ-036 SHALL cover: qa=3 with SA held GREEN and DEPART_CYC=2 -> qa steps 2,1,0 every 2 cycles, and TA=0 after the last departure.
REQ-037 SHALL cover: qb=15 with arr_b pulsed while SB=RED -> qb stays 15 and drop_b=1 for one cycle; arr_b in a departure cycle -> qb unchanged, no drop.
REQ-038 SHALL cover: SA sequence GREEN->RED -> viol=1, viol_code=3; a later SA=SB=GREEN conflict leaves viol_code=3.
REQ-039 SHALL cover: after reset, SA=11 and SB=GREEN in the same cycle -> viol_code=1 (priority over conflict); rebuilding without TRAFFIC_CHECK_EN -> viol=0.
REQ-040 SHALL cover: reset asserted with qa=5 mid-green -> qa=0, TA=0 immediately; the first post-release cycle with SA=GREEN raises no violation.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light codes and violation codes shared by the queue sensor
package traffic_pkg;

  typedef enum logic [1:0] {
    RED       = 2'b00,
    YELLOW    = 2'b01,
    GREEN     = 2'b10,
    LIGHT_BAD = 2'b11
  } light_t;

  localparam logic [2:0] VIOL_NONE     = 3'd0;
  localparam logic [2:0] VIOL_BAD_CODE = 3'd1;
  localparam logic [2:0] VIOL_CONFLICT = 3'd2;
  localparam logic [2:0] VIOL_SEQ_A    = 3'd3;
  localparam logic [2:0] VIOL_SEQ_B    = 3'd4;

endpackage

// File: rtl/traffic_lane.sv
// rtl/traffic_lane.sv - one street: queue counter, departure timer, drop pulse, sequence check
// Sequence check is present only when TRAFFIC_CHECK_EN is defined.
module traffic_lane
  import traffic_pkg::*;
#(
  parameter int QW         = 4,
  parameter int DEPART_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  light_t        i_light,
  input  logic          i_arr,
  output logic [QW-1:0] o_q,
  output logic          o_drop
`ifdef TRAFFIC_CHECK_EN
  ,
  output logic          o_seq_err
`endif
);

  localparam int TW = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam logic [QW-1:0] QMAX = '1;

  logic [TW-1:0] r_timer;
  logic [QW-1:0] r_q;
  logic          r_drop;
  logic          w_green;
  logic          w_dep_slot;
  logic          w_dep;
  logic          w_full;

  // Code 11 falls through as not-GREEN, so a bad light never moves the queue.
  assign w_green    = (i_light == GREEN);
  assign w_dep_slot = (r_timer == TW'(DEPART_CYC - 1));
  assign w_dep      = w_green && w_dep_slot && (r_q != '0);
  assign w_full     = (r_q == QMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= '0;
      r_q     <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_timer <= (!w_green || w_dep_slot) ? '0 : r_timer + 1'b1;
      r_drop  <= i_arr && !w_dep && w_full;
      if (i_arr && !w_dep && !w_full)
        r_q <= r_q + 1'b1;
      else if (w_dep && !i_arr)
        r_q <= r_q - 1'b1;
    end
  end

  assign o_q    = r_q;
  assign o_drop = r_drop;

`ifdef TRAFFIC_CHECK_EN
  light_t r_prev;
  logic   w_legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_prev <= RED;
    else
      r_prev <= i_light;
  end

  assign w_legal = (i_light == r_prev)
                || (r_prev == GREEN  && i_light == YELLOW)
                || (r_prev == YELLOW && i_light == RED)
                || (r_prev == RED    && i_light == GREEN);

  assign o_seq_err = !w_legal;
`endif

endmodule

// File: rtl/traffic_queue_sensor.sv
// rtl/traffic_queue_sensor.sv - two-street queue sensor with optional protocol checker
// Violation checker is built only when TRAFFIC_CHECK_EN is defined.
module traffic_queue_sensor
  import traffic_pkg::*;
#(
  parameter int QW         = 4,
  parameter int DEPART_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    SA,
  input  logic [1:0]    SB,
  input  logic          arr_a,
  input  logic          arr_b,
  output logic          TA,
  output logic          TB,
  output logic [QW-1:0] qa,
  output logic [QW-1:0] qb,
  output logic          drop_a,
  output logic          drop_b,
  output logic          viol,
  output logic [2:0]    viol_code
);

`ifdef TRAFFIC_CHECK_EN
  logic w_seq_a;
  logic w_seq_b;
`endif

  traffic_lane #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_lane_a (
    .clk       (clk),
    .reset     (reset),
    .i_light   (light_t'(SA)),
    .i_arr     (arr_a),
    .o_q       (qa),
    .o_drop    (drop_a)
`ifdef TRAFFIC_CHECK_EN
    ,
    .o_seq_err (w_seq_a)
`endif
  );

  traffic_lane #(.QW(QW), .DEPART_CYC(DEPART_CYC)) u_lane_b (
    .clk       (clk),
    .reset     (reset),
    .i_light   (light_t'(SB)),
    .i_arr     (arr_b),
    .o_q       (qb),
    .o_drop    (drop_b)
`ifdef TRAFFIC_CHECK_EN
    ,
    .o_seq_err (w_seq_b)
`endif
  );

  // Presence flags come straight off the registered counts.
  assign TA = (qa != '0);
  assign TB = (qb != '0);

`ifdef TRAFFIC_CHECK_EN
  logic       w_bad;
  logic       w_conflict;
  logic [2:0] w_code;
  logic       r_viol;
  logic [2:0] r_code;

  assign w_bad      = (SA == LIGHT_BAD) || (SB == LIGHT_BAD);
  assign w_conflict = (SA != RED) && (SB != RED);

  always_comb begin
    w_code = VIOL_NONE;
    if (w_bad)
      w_code = VIOL_BAD_CODE;
    else if (w_conflict)
      w_code = VIOL_CONFLICT;
    else if (w_seq_a)
      w_code = VIOL_SEQ_A;
    else if (w_seq_b)
      w_code = VIOL_SEQ_B;
  end

  // Only the first violation is recorded; the flag is sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_viol <= 1'b0;
      r_code <= VIOL_NONE;
    end else if (!r_viol && (w_code != VIOL_NONE)) begin
      r_viol <= 1'b1;
      r_code <= w_code;
    end
  end

  assign viol      = r_viol;
  assign viol_code = r_code;
`else
  assign viol      = 1'b0;
  assign viol_code = VIOL_NONE;
`endif

endmodule

// File: tb/tb_traffic_queue_sensor.sv
// tb/tb_traffic_queue_sensor.sv - directed self-checking bench for traffic_queue_sensor
// Violation expectations follow whether TRAFFIC_CHECK_EN is defined for the build.
module tb_traffic_queue_sensor;
  import traffic_pkg::*;

`ifdef TRAFFIC_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] SA;
  logic [1:0] SB;
  logic       arr_a;
  logic       arr_b;
  logic       TA;
  logic       TB;
  logic [3:0] qa;
  logic [3:0] qb;
  logic       drop_a;
  logic       drop_b;
  logic       viol;
  logic [2:0] viol_code;

  int errors = 0;
  int checks = 0;

  traffic_queue_sensor #(.QW(4), .DEPART_CYC(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .SA        (SA),
    .SB        (SB),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .TA        (TA),
    .TB        (TB),
    .qa        (qa),
    .qb        (qb),
    .drop_a    (drop_a),
    .drop_b    (drop_b),
    .viol      (viol),
    .viol_code (viol_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    SA = RED; SB = RED; arr_a = 1'b0; arr_b = 1'b0; reset = 1'b0;
    #3;
    chk("rst_qa", qa, 0);
    chk("rst_qb", qb, 0);
    chk("rst_ta", TA, 0);
    chk("rst_tb", TB, 0);
    chk("rst_drop_a", drop_a, 0);
    chk("rst_drop_b", drop_b, 0);
    chk("rst_viol", viol, 0);
    chk("rst_code", viol_code, 0);
    step(); step(); reset = 1'b1;

    // Three arrivals on a red street
    arr_a = 1'b1; step();
    chk("arr_qa1", qa, 1);
    chk("arr_ta1", TA, 1);
    arr_a = 1'b0; step();
    arr_a = 1'b1; step();
    arr_a = 1'b0; step();
    arr_a = 1'b1; step();
    arr_a = 1'b0;
    chk("arr_qa3", qa, 3);
    step(); step();
    chk("red_hold_qa", qa, 3);

    // Green drains one vehicle every two cycles
    SA = GREEN;
    step(); chk("dep_qa_c1", qa, 3);
    step(); chk("dep_qa_c2", qa, 2);
    step(); chk("dep_qa_c3", qa, 2);
    step(); chk("dep_qa_c4", qa, 1);
    step(); chk("dep_qa_c5", qa, 1);
    step(); chk("dep_qa_c6", qa, 0);
    chk("dep_ta_off", TA, 0);
    step(); chk("dep_qa_empty", qa, 0);
    SA = YELLOW; step();
    SA = RED; step();
    chk("legal_cycle_viol", viol, 0);

    // Saturation and drop on street B
    arr_b = 1'b1;
    repeat (15) step();
    chk("sat_qb15", qb, 15);
    chk("sat_tb", TB, 1);
    chk("sat_nodrop", drop_b, 0);
    step();
    chk("sat_hold", qb, 15);
    chk("sat_drop", drop_b, 1);
    arr_b = 1'b0; step();
    chk("sat_drop_end", drop_b, 0);
    chk("sat_hold2", qb, 15);
    SB = GREEN; step();
    arr_b = 1'b1; step();
    chk("arr_dep_qb", qb, 15);
    chk("arr_dep_nodrop", drop_b, 0);
    arr_b = 1'b0; step(); step();
    chk("dep_qb14", qb, 14);
    SB = YELLOW; step();
    SB = RED; step();
    chk("b_cycle_viol", viol, 0);

    // Illegal GREEN->RED on A, then a conflict that must not overwrite the code
    SA = GREEN; step();
    SA = RED; step();
    chk("seq_a_viol", viol, CHK_EN ? 1 : 0);
    chk("seq_a_code", viol_code, CHK_EN ? 3 : 0);
    SA = GREEN; SB = GREEN; step(); step();
    chk("sticky_viol", viol, CHK_EN ? 1 : 0);
    chk("sticky_code", viol_code, CHK_EN ? 3 : 0);
    SA = RED; SB = RED;

    // Asynchronous reset clears the sticky flag
    reset = 1'b0; #2;
    chk("arst_viol", viol, 0);
    chk("arst_code", viol_code, 0);
    step(); reset = 1'b1;
    SA = 2'b11; SB = GREEN; step();
    chk("bad_code_viol", viol, CHK_EN ? 1 : 0);
    chk("bad_code_code", viol_code, CHK_EN ? 1 : 0);
    chk("bad_code_qa", qa, 0);

    reset = 1'b0; step(); reset = 1'b1;
    SA = GREEN; SB = YELLOW; step();
    chk("conflict_code", viol_code, CHK_EN ? 2 : 0);

    reset = 1'b0; step(); reset = 1'b1;
    SA = YELLOW; SB = RED; step();
    chk("seq_a_only_code", viol_code, CHK_EN ? 3 : 0);

    reset = 1'b0; step(); reset = 1'b1;
    SA = RED; SB = YELLOW; step();
    chk("seq_b_only_code", viol_code, CHK_EN ? 4 : 0);

    // Reset mid-green with a loaded queue
    reset = 1'b0; step(); reset = 1'b1;
    SA = RED; SB = RED; arr_a = 1'b1;
    repeat (5) step();
    arr_a = 1'b0;
    chk("load_qa5", qa, 5);
    SA = GREEN; step();
    chk("green_qa5", qa, 5);
    #2; reset = 1'b0; #1;
    chk("mid_rst_qa", qa, 0);
    chk("mid_rst_ta", TA, 0);
    step(); reset = 1'b1;
    step();
    chk("post_rel_viol", viol, 0);
    chk("post_rel_qa", qa, 0);
    step(); step();
    chk("post_rel_viol2", viol, 0);
    chk("post_rel_qa2", qa, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
